usb_ep_trans_fifo: RTL and testbench
====================================

USB_EP_TRANS_FIFO -- requirements
Module: usb_ep_trans_fifo

Interface
REQ-001 SHALL have parameter DATA_WID, default 8, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning the number of storage words; it must be a power of two and at least 2.
REQ-003 SHALL have port clk48_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port fillData_i, input, DATA_WID: the write word.
REQ-006 SHALL have port fillValid_i, input, 1: write request; a word is accepted when fillValid_i && !full_o.
REQ-007 SHALL have port fillTransDone_i, input, 1: ends the current write transaction.
REQ-008 SHALL have port fillTransSuccess_i, input, 1: sampled with fillTransDone_i; 1 commits, 0 rolls back.
REQ-009 SHALL have port full_o, output, 1: no write space is available.
REQ-010 SHALL have port popData_i, input, 1: read advance; honoured only when dataAvailable_o is 1.
REQ-011 SHALL have port popTransDone_i, input, 1: ends the current read transaction.
REQ-012 SHALL have port popTransSuccess_i, input, 1: sampled with popTransDone_i; 1 commits, 0 rewinds.
REQ-013 SHALL have port dataAvailable_o, output, 1: data_o holds a committed, unread word.
REQ-014 SHALL have port data_o, output, DATA_WID: first-word-fall-through read data.

Function
REQ-015 SHALL keep four pointers, each log2(DEPTH)+1 bits wide (MSB is the wrap bit): wrPtr and wrCommitPtr (write side), rdPtr and rdCommitPtr (read side).
REQ-016 SHALL drive full_o = ((wrPtr - rdCommitPtr) == DEPTH), so uncommitted reads are never overwritten.
REQ-017 SHALL drive dataAvailable_o = (rdPtr != wrCommitPtr), so uncommitted writes are never readable.
REQ-018 SHALL drive data_o = mem[rdPtr] combinationally when dataAvailable_o is 1, and 0 otherwise.
REQ-019 SHALL, on an accepted write, store fillData_i at mem[wrPtr] and increment wrPtr modulo 2*DEPTH.
REQ-020 SHALL, on an honoured pop, increment rdPtr modulo 2*DEPTH; data_o shows the next word in the following cycle.
REQ-021 SHALL, on fillTransDone_i with success, load wrCommitPtr with the post-cycle wrPtr, including any word accepted in that same cycle.
REQ-022 SHALL, on fillTransDone_i with failure, load wrPtr from wrCommitPtr, discarding any word accepted in that same cycle.
REQ-023 SHALL, on popTransDone_i with success, load rdCommitPtr with the post-cycle rdPtr, including any pop honoured in that same cycle.
REQ-024 SHALL, on popTransDone_i with failure, load rdPtr from rdCommitPtr so the same words replay; this is used for IN retransmission after a missing ACK.
REQ-025 SHALL ignore writes while full_o is 1 and pops while dataAvailable_o is 0, without corrupting any pointer.
REQ-026 SHALL keep the write and read sides independent, so commit, rollback and data events on both sides in the same cycle all take effect.
REQ-027 SHALL make a write commit visible to dataAvailable_o one cycle later, and a read commit visible to full_o one cycle later.
REQ-028 SHALL handle pointer wrap-around through the MSB wrap bit, with no special case at DEPTH-1 to 0.

Reset
REQ-029 SHALL, while rst_n_i is 0, force all four pointers to 0, full_o=0, dataAvailable_o=0 and data_o=0; memory contents are not reset.
REQ-030 SHALL abandon any open write or read transaction when reset occurs mid-transaction.

Configuration
REQ-031 SHALL, when USB_EP_FIFO_LEVEL_EN is defined, add outputs fillLevel_o = wrCommitPtr - rdCommitPtr and freeSpace_o = DEPTH - (wrPtr - rdCommitPtr), each log2(DEPTH)+1 bits, registered, reset to 0 and DEPTH respectively, updating one cycle after the pointers.
REQ-032 SHALL, when USB_EP_FIFO_LEVEL_EN is undefined, omit both ports and their logic, with all other behaviour identical.

Structure
REQ-033 SHALL take constant USB_EP_FIFO_DEFAULT_DEPTH and the commit/rollback encoding typedef (TRANS_ROLLBACK=0, TRANS_COMMIT=1) from usb_ep_pkg.
REQ-034 SHALL place storage in a sub-module usb_ep_fifo_mem: simple dual-port, one synchronous write port, one asynchronous read port, parametrised by DATA_WID and DEPTH.

Verification
REQ-035 SHALL cover commit visibility: DEPTH=8, write 0xA1,0xA2,0xA3 with no commit -> dataAvailable_o=0; commit -> next cycle dataAvailable_o=1, data_o=0xA1.
REQ-036 SHALL cover write rollback: write 0x11 and 0x22, commit, write 0x33, fail -> reads return 0x11,0x22, then dataAvailable_o=0.
REQ-037 SHALL cover read replay: 4 words committed, pop 3, popTransDone_i=1 with popTransSuccess_i=0 -> data_o returns to word 0; pop 4 then commit -> full_o=0 and free space is 8.
REQ-038 SHALL cover full guard: DEPTH=8, write 8 and commit, pop 8 without commit -> full_o stays 1 and a 9th write is ignored; read commit -> next cycle full_o=0.
REQ-039 SHALL cover wrap and simultaneity: 20 commit/pop cycles over DEPTH=8 with fillTransDone_i and the last write in the same cycle -> in-order data, no loss; assert reset mid-transaction -> all outputs 0.

Source files
------------

// File: rtl/usb_ep_pkg.sv
// usb_ep_pkg
// Shared constants and types for the USB endpoint transactional FIFO.
//   USB_EP_FIFO_DEFAULT_DEPTH : default number of storage words
//   trans_result_e            : encoding of the *TransSuccess_i strobes
//                               (0 = roll back / rewind, 1 = commit)
package usb_ep_pkg;

    localparam int USB_EP_FIFO_DEFAULT_DEPTH = 64;

    typedef enum logic {
        TRANS_ROLLBACK = 1'b0,
        TRANS_COMMIT   = 1'b1
    } trans_result_e;

    function automatic logic is_commit(input logic success);
        return trans_result_e'(success) == TRANS_COMMIT;
    endfunction

endpackage

// File: rtl/usb_ep_fifo_mem.sv
// usb_ep_fifo_mem
// Simple dual-port storage for the endpoint FIFO: one synchronous write
// port and one asynchronous (combinational) read port. Contents are not
// reset.
// Ports:
//   clk_i     : write clock (rising edge)
//   wrEn_i    : write enable
//   wrAddr_i  : write address
//   wrData_i  : write data
//   rdAddr_i  : read address
//   rdData_o  : read data, combinational from rdAddr_i
module usb_ep_fifo_mem #(
    parameter int DATA_WID = 8,
    parameter int DEPTH    = 64
) (
    input  logic                     clk_i,
    input  logic                     wrEn_i,
    input  logic [$clog2(DEPTH)-1:0] wrAddr_i,
    input  logic [DATA_WID-1:0]      wrData_i,
    input  logic [$clog2(DEPTH)-1:0] rdAddr_i,
    output logic [DATA_WID-1:0]      rdData_o
);

    logic [DATA_WID-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wrEn_i) r_mem[wrAddr_i] <= wrData_i;
    end

    assign rdData_o = r_mem[rdAddr_i];

endmodule

// File: rtl/usb_ep_trans_fifo.sv
// usb_ep_trans_fifo
// Transactional FIFO for a USB endpoint. Writes become readable only after
// the fill transaction commits; a failed fill discards the whole packet.
// Reads are released (space freed) only after the pop transaction commits;
// a failed pop rewinds so the same words replay (IN retransmit).
// Optional feature macro: USB_EP_FIFO_LEVEL_EN adds registered
// fillLevel_o / freeSpace_o outputs.
// Ports:
//   clk48_i            : clock, rising edge
//   rst_n_i            : asynchronous active-low reset
//   fillData_i         : write word
//   fillValid_i        : write request, accepted when !full_o
//   fillTransDone_i    : end of write transaction
//   fillTransSuccess_i : 1 commit / 0 roll back (with fillTransDone_i)
//   full_o             : no write space (counts uncommitted reads as used)
//   popData_i          : read advance, honoured when dataAvailable_o
//   popTransDone_i     : end of read transaction
//   popTransSuccess_i  : 1 commit / 0 rewind (with popTransDone_i)
//   dataAvailable_o    : data_o holds a committed unread word
//   data_o             : first-word-fall-through read data (0 when empty)
//   fillLevel_o        : (optional) committed words stored
//   freeSpace_o        : (optional) words that may still be written
module usb_ep_trans_fifo
    import usb_ep_pkg::*;
#(
    parameter int DATA_WID = 8,
    // Must be a power of two and at least 2.
    parameter int DEPTH    = USB_EP_FIFO_DEFAULT_DEPTH
) (
    input  logic                     clk48_i,
    input  logic                     rst_n_i,
    input  logic [DATA_WID-1:0]      fillData_i,
    input  logic                     fillValid_i,
    input  logic                     fillTransDone_i,
    input  logic                     fillTransSuccess_i,
    output logic                     full_o,
    input  logic                     popData_i,
    input  logic                     popTransDone_i,
    input  logic                     popTransSuccess_i,
    output logic                     dataAvailable_o,
`ifdef USB_EP_FIFO_LEVEL_EN
    output logic [$clog2(DEPTH):0]   fillLevel_o,
    output logic [$clog2(DEPTH):0]   freeSpace_o,
`endif
    output logic [DATA_WID-1:0]      data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;  // MSB is the wrap bit

    typedef logic [PW-1:0] ptr_t;

    ptr_t r_wrPtr, r_wrCommitPtr, r_rdPtr, r_rdCommitPtr;

    logic                w_wrAccept, w_popAccept;
    ptr_t                w_wrPtrNext, w_rdPtrNext, w_wrUsed;
    logic [DATA_WID-1:0] w_memRd;

    // Space is measured against the committed read pointer so words that
    // may still be replayed are never overwritten.
    assign w_wrUsed        = r_wrPtr - r_rdCommitPtr;
    assign full_o          = (w_wrUsed == ptr_t'(DEPTH));
    // Only committed writes are visible to the reader.
    assign dataAvailable_o = (r_rdPtr != r_wrCommitPtr);

    assign w_wrAccept  = fillValid_i && !full_o;
    assign w_popAccept = popData_i && dataAvailable_o;
    assign w_wrPtrNext = r_wrPtr + ptr_t'(w_wrAccept);
    assign w_rdPtrNext = r_rdPtr + ptr_t'(w_popAccept);

    // Write side. A word accepted in the rollback cycle lands in memory but
    // the pointer rewind makes it unreachable.
    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wrPtr       <= '0;
            r_wrCommitPtr <= '0;
        end else if (fillTransDone_i) begin
            if (is_commit(fillTransSuccess_i)) begin
                r_wrPtr       <= w_wrPtrNext;
                r_wrCommitPtr <= w_wrPtrNext;
            end else begin
                r_wrPtr       <= r_wrCommitPtr;
            end
        end else begin
            r_wrPtr <= w_wrPtrNext;
        end
    end

    // Read side, independent of the write side.
    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rdPtr       <= '0;
            r_rdCommitPtr <= '0;
        end else if (popTransDone_i) begin
            if (is_commit(popTransSuccess_i)) begin
                r_rdPtr       <= w_rdPtrNext;
                r_rdCommitPtr <= w_rdPtrNext;
            end else begin
                r_rdPtr       <= r_rdCommitPtr;
            end
        end else begin
            r_rdPtr <= w_rdPtrNext;
        end
    end

    usb_ep_fifo_mem #(
        .DATA_WID (DATA_WID),
        .DEPTH    (DEPTH)
    ) u_mem (
        .clk_i    (clk48_i),
        .wrEn_i   (w_wrAccept),
        .wrAddr_i (r_wrPtr[AW-1:0]),
        .wrData_i (fillData_i),
        .rdAddr_i (r_rdPtr[AW-1:0]),
        .rdData_o (w_memRd)
    );

    assign data_o = dataAvailable_o ? w_memRd : '0;

`ifdef USB_EP_FIFO_LEVEL_EN
    ptr_t r_fillLevel, r_freeSpace;

    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_fillLevel <= '0;
            r_freeSpace <= ptr_t'(DEPTH);
        end else begin
            r_fillLevel <= r_wrCommitPtr - r_rdCommitPtr;
            r_freeSpace <= ptr_t'(DEPTH) - w_wrUsed;
        end
    end

    assign fillLevel_o = r_fillLevel;
    assign freeSpace_o = r_freeSpace;
`endif

endmodule

// File: tb/tb_usb_ep_trans_fifo.sv
module tb_usb_ep_trans_fifo;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          clk48_i = 1'b0;
    logic          rst_n_i;
    logic [DW-1:0] fillData_i;
    logic          fillValid_i, fillTransDone_i, fillTransSuccess_i;
    logic          popData_i, popTransDone_i, popTransSuccess_i;
    logic          full_o, dataAvailable_o;
    logic [DW-1:0] data_o;

    int checks = 0;
    int errors = 0;

    usb_ep_trans_fifo #(.DATA_WID(DW), .DEPTH(DP)) dut (
        .clk48_i            (clk48_i),
        .rst_n_i            (rst_n_i),
        .fillData_i         (fillData_i),
        .fillValid_i        (fillValid_i),
        .fillTransDone_i    (fillTransDone_i),
        .fillTransSuccess_i (fillTransSuccess_i),
        .full_o             (full_o),
        .popData_i          (popData_i),
        .popTransDone_i     (popTransDone_i),
        .popTransSuccess_i  (popTransSuccess_i),
        .dataAvailable_o    (dataAvailable_o),
        .data_o             (data_o)
    );

    always #5 clk48_i = ~clk48_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk48_i);
        #1;
    endtask

    task automatic idle_in();
        fillValid_i = 0; fillTransDone_i = 0; fillTransSuccess_i = 0;
        popData_i = 0;   popTransDone_i = 0;  popTransSuccess_i = 0;
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic done, input logic succ);
        fillData_i = d; fillValid_i = 1; fillTransDone_i = done; fillTransSuccess_i = succ;
        cyc();
        idle_in();
    endtask

    task automatic wdone(input logic succ);
        fillTransDone_i = 1; fillTransSuccess_i = succ;
        cyc();
        idle_in();
    endtask

    task automatic pop(input logic done, input logic succ);
        popData_i = 1; popTransDone_i = done; popTransSuccess_i = succ;
        cyc();
        idle_in();
    endtask

    task automatic rdone(input logic succ);
        popTransDone_i = 1; popTransSuccess_i = succ;
        cyc();
        idle_in();
    endtask

    initial begin
        rst_n_i = 0; fillData_i = '0;
        idle_in();
        #12;
        chk("rst_full", full_o, 0);
        chk("rst_avail", dataAvailable_o, 0);
        chk("rst_data", data_o, 0);
        rst_n_i = 1;
        cyc();

        // Commit visibility
        wr(8'hA1, 0, 0); wr(8'hA2, 0, 0); wr(8'hA3, 0, 0);
        chk("nocommit_avail", dataAvailable_o, 0);
        chk("nocommit_data", data_o, 0);
        wdone(1);
        chk("commit_avail", dataAvailable_o, 1);
        chk("commit_data", data_o, 8'hA1);
        pop(1, 1); chk("rd_a2", data_o, 8'hA2);
        pop(1, 1); chk("rd_a3", data_o, 8'hA3);
        pop(1, 1); chk("drain1_avail", dataAvailable_o, 0);

        // Write rollback
        wr(8'h11, 0, 0); wr(8'h22, 1, 1);
        wr(8'h33, 0, 0); wdone(0);
        wr(8'h44, 1, 0);  // write in the rollback cycle is discarded
        chk("rb_data0", data_o, 8'h11);
        pop(1, 1); chk("rb_data1", data_o, 8'h22);
        pop(1, 1); chk("rb_empty", dataAvailable_o, 0);

        // Read replay
        wr(8'h50, 0, 0); wr(8'h51, 0, 0); wr(8'h52, 0, 0); wr(8'h53, 1, 1);
        pop(0, 0); pop(0, 0); pop(0, 0);
        chk("rp_word3", data_o, 8'h53);
        rdone(0);
        chk("rp_rewind", data_o, 8'h50);
        pop(0, 0); chk("rp_w1", data_o, 8'h51);
        pop(0, 0); chk("rp_w2", data_o, 8'h52);
        pop(0, 0); chk("rp_w3", data_o, 8'h53);
        pop(1, 1);
        chk("rp_empty", dataAvailable_o, 0);
        chk("rp_notfull", full_o, 0);

        // Full guard (pointers wrap through here)
        for (int i = 0; i < DP; i++) begin
            chk("fg_notfull", full_o, 0);
            wr(8'h80 + 8'(i), (i == DP - 1), (i == DP - 1));
        end
        chk("fg_full", full_o, 1);
        for (int i = 0; i < DP; i++) begin
            chk("fg_rd", data_o, 8'h80 + 8'(i));
            pop(0, 0);
        end
        chk("fg_full_after_pop", full_o, 1);
        chk("fg_avail_after_pop", dataAvailable_o, 0);
        wr(8'h99, 1, 1);  // ignored while full
        chk("fg_still_full", full_o, 1);
        chk("fg_9th_ignored", dataAvailable_o, 0);
        rdone(1);
        chk("fg_released", full_o, 0);
        wr(8'h9A, 1, 1);
        chk("fg_next_data", data_o, 8'h9A);
        pop(1, 1);
        chk("fg_empty", dataAvailable_o, 0);

        // Wrap and simultaneity: commit-with-write and pop-with-commit each cycle
        for (int i = 0; i < 20; i++) begin
            chk("sim_avail", dataAvailable_o, (i > 0));
            if (i > 0) chk("sim_data", data_o, 8'hC0 + 8'(i - 1));
            fillData_i = 8'hC0 + 8'(i); fillValid_i = 1;
            fillTransDone_i = 1; fillTransSuccess_i = 1;
            popData_i = (i > 0); popTransDone_i = 1; popTransSuccess_i = 1;
            cyc();
            idle_in();
        end
        chk("sim_last", data_o, 8'hC0 + 8'd19);
        pop(1, 1);
        chk("sim_empty", dataAvailable_o, 0);
        chk("sim_notfull", full_o, 0);

        // Reset mid-transaction
        wr(8'hD0, 1, 1);
        wr(8'hD1, 0, 0);
        pop(0, 0);
        wr(8'hD2, 1, 1);
        chk("mr_pre_avail", dataAvailable_o, 1);
        #2 rst_n_i = 0;
        #1;
        chk("mr_full", full_o, 0);
        chk("mr_avail", dataAvailable_o, 0);
        chk("mr_data", data_o, 0);
        #3 rst_n_i = 1;
        cyc();
        chk("mr_post_avail", dataAvailable_o, 0);
        chk("mr_post_full", full_o, 0);
        wr(8'hE5, 1, 1);
        chk("mr_fresh_data", data_o, 8'hE5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
